// File: rtl/collision_monitor.sv
// collision_monitor
// Per-channel open-drain bus contention monitor. Each channel synchronises
// its sampled bus level and blanks mismatches for a guard window after every
// transmit edge. A mismatch is only declared a collision after it persists for
// a number of consecutive cycles. A declared collision raises a sticky flag, a
// one-cycle strobe and a saturating counter. At most one collision is declared
// per transmit (n_SEND low) period.
module collision_monitor #(
    parameter int N_CHANNELS      = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int GUARD_CYCLES    = 4,
    parameter int FILTER_CYCLES   = 3,
    parameter int COUNT_WIDTH     = 8,
    parameter int CHECK_DRIVE_LOW = 0
) (
    input  logic                              CLK,
    input  logic                              n_RESET,
    input  logic [N_CHANNELS-1:0]             WRITE_DATA,
    input  logic [N_CHANNELS-1:0]             n_SEND,
    input  logic [N_CHANNELS-1:0]             DATALINE,
    input  logic [N_CHANNELS-1:0]             CLEAR,
    output logic [N_CHANNELS-1:0]             COLLISION_DETECTED,
    output logic [N_CHANNELS-1:0]             COLLISION_PULSE,
    output logic [N_CHANNELS*COUNT_WIDTH-1:0] COLLISION_COUNT,
    output logic                              ANY_COLLISION
);

    // Counter widths sized to hold the full load / terminal values.
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    localparam logic [GW-1:0]          GUARD_LOAD   = GW'(GUARD_CYCLES);
    localparam logic [FW-1:0]          FILTER_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = {COUNT_WIDTH{1'b1}};
    localparam logic                   DRIVE_LOW_EN = (CHECK_DRIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GUARD   = 2'd1,
        ST_MONITOR = 2'd2,
        ST_LATCHED = 2'd3
    } state_t;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   line_s;
        logic                   mismatch_s;
        logic                   wd_change_s;
        logic                   declare_s;
        logic                   wd_q;

        state_t                 state_q;
        state_t                 state_d;
        logic [GW-1:0]          guard_q;
        logic [GW-1:0]          guard_d;
        logic [FW-1:0]          filter_q;
        logic [FW-1:0]          filter_d;

        logic                   flag_q;
        logic                   flag_d;
        logic                   pulse_q;
        logic                   pulse_d;
        logic [COUNT_WIDTH-1:0] count_q;
        logic [COUNT_WIDTH-1:0] count_d;

        // Bring the asynchronous bus level into the clock domain; idles high.
        always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET) begin
                sync_q <= {SYNC_STAGES{1'b1}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], DATALINE[i]};
            end
        end

        assign line_s = sync_q[SYNC_STAGES-1];

        // Remember the previously presented bit so a transmit edge can re-arm the guard.
        always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET) begin
                wd_q <= 1'b1;
            end else begin
                wd_q <= WRITE_DATA[i];
            end
        end

        // Classify the current cycle: bus level disagrees with what this channel presents.
        always_comb begin
            mismatch_s  = 1'b0;
            wd_change_s = (WRITE_DATA[i] != wd_q);
            if (!n_SEND[i]) begin
                if (WRITE_DATA[i] && !line_s) begin
                    mismatch_s = 1'b1;
                end else if (DRIVE_LOW_EN && !WRITE_DATA[i] && line_s) begin
                    mismatch_s = 1'b1;
                end else begin
                    mismatch_s = 1'b0;
                end
            end else begin
                mismatch_s = 1'b0;
            end
        end

        // Detection FSM state, guard timer and glitch filter registers.
        always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET) begin
                state_q  <= ST_IDLE;
                guard_q  <= '0;
                filter_q <= '0;
            end else begin
                state_q  <= state_d;
                guard_q  <= guard_d;
                filter_q <= filter_d;
            end
        end

        // Next-state logic: guard blanking, filtered monitoring, one declaration per transmit.
        always_comb begin
            state_d   = state_q;
            guard_d   = guard_q;
            filter_d  = filter_q;
            declare_s = 1'b0;
            if (n_SEND[i]) begin
                // Transmit ended (or never started): drop back to idle from anywhere.
                state_d  = ST_IDLE;
                guard_d  = '0;
                filter_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // A held-low n_SEND counts as a fresh transmit, including after reset.
                        state_d  = ST_GUARD;
                        guard_d  = GUARD_LOAD;
                        filter_d = '0;
                    end
                    ST_GUARD: begin
                        if (wd_change_s) begin
                            guard_d  = GUARD_LOAD;
                            filter_d = '0;
                        end else if (guard_q <= GW'(1)) begin
                            state_d  = ST_MONITOR;
                            guard_d  = '0;
                        end else begin
                            guard_d  = guard_q - GW'(1);
                        end
                    end
                    ST_MONITOR: begin
                        if (wd_change_s) begin
                            // New bit on the wire: the line needs time to follow it.
                            state_d  = ST_GUARD;
                            guard_d  = GUARD_LOAD;
                            filter_d = '0;
                        end else if (mismatch_s) begin
                            if (filter_q == FILTER_LAST) begin
                                state_d   = ST_LATCHED;
                                filter_d  = '0;
                                declare_s = 1'b1;
                            end else begin
                                filter_d  = filter_q + FW'(1);
                            end
                        end else begin
                            filter_d = '0;
                        end
                    end
                    ST_LATCHED: begin
                        // Already reported for this transmit; wait for n_SEND to rise.
                        state_d = ST_LATCHED;
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        guard_d  = '0;
                        filter_d = '0;
                    end
                endcase
            end
        end

        // Report next-state: a declaration takes priority over a coincident clear.
        always_comb begin
            flag_d  = flag_q;
            count_d = count_q;
            pulse_d = declare_s;
            if (declare_s) begin
                flag_d = 1'b1;
                if (CLEAR[i]) begin
                    count_d = COUNT_WIDTH'(1);
                end else if (count_q == COUNT_MAX) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end else if (CLEAR[i]) begin
                flag_d  = 1'b0;
                count_d = '0;
            end else begin
                flag_d  = flag_q;
                count_d = count_q;
            end
        end

        // Registered sticky flag, strobe and saturating collision counter.
        always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET) begin
                flag_q  <= 1'b0;
                pulse_q <= 1'b0;
                count_q <= '0;
            end else begin
                flag_q  <= flag_d;
                pulse_q <= pulse_d;
                count_q <= count_d;
            end
        end

        assign COLLISION_DETECTED[i]                          = flag_q;
        assign COLLISION_PULSE[i]                             = pulse_q;
        assign COLLISION_COUNT[i*COUNT_WIDTH +: COUNT_WIDTH]  = count_q;
    end

    assign ANY_COLLISION = |COLLISION_DETECTED;

endmodule
